count_tracker: RTL and testbench



---
 rtl/count_tracker.sv | 128 ++++++++++++
 tb/tb_count_tracker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/count_tracker.sv
// rtl/count_tracker.sv - mod-11 digit stream tracker with carry accumulation; optional err_count via COUNT_TRACKER_ERRCNT_EN
module count_tracker #(
    parameter int MODULO = 11,
    parameter int HIGH_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        in_count,
    input  logic              in_carry,
    input  logic              in_dir,
    input  logic              resync,
    output logic [3:0]        low_count,
    output logic [HIGH_W-1:0] high_count,
    output logic              locked,
    output logic              err,
`ifdef COUNT_TRACKER_ERRCNT_EN
    output logic [7:0]        err_count,
`endif
    output logic              wrap
);

    localparam logic [3:0] LAST = 4'(MODULO - 1);
    localparam logic [HIGH_W-1:0] HIGH_MAX = {HIGH_W{1'b1}};

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t state;

    logic [3:0] next_up;
    logic [3:0] next_down;
    logic       carry_up;
    logic       carry_down;
    logic       ref_ok;
    logic       step_ok;
    logic       acquiring;

    // Expected successor of the current digit in each direction, and whether the incoming sample matches
    always_comb begin
        next_up    = (low_count == LAST) ? 4'd0 : low_count + 4'd1;
        next_down  = (low_count == 4'd0) ? LAST : low_count - 4'd1;
        carry_up   = (low_count == LAST);
        carry_down = (low_count == 4'd0);
        ref_ok     = (in_count <= LAST);
        acquiring  = resync || (state == SYNC);
        if (in_dir)
            step_ok = ref_ok && (in_count == next_up) && (in_carry == carry_up);
        else
            step_ok = ref_ok && (in_count == next_down) && (in_carry == carry_down);
    end

    // Tracking state machine: acquire a reference, follow legal steps, latch errors until resync
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SYNC;
            low_count  <= 4'd0;
            high_count <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (acquiring) begin
                // resync (or the first sample after it) takes this sample as the new reference
                err <= 1'b0;
                if (in_valid) begin
                    if (ref_ok) begin
                        low_count <= in_count;
                        state     <= TRACK;
                        locked    <= 1'b1;
                    end else begin
                        err    <= 1'b1;
                        state  <= ERR;
                        locked <= 1'b0;
                    end
                end else begin
                    state  <= SYNC;
                    locked <= 1'b0;
                end
            end else if (state == TRACK && in_valid) begin
                if (step_ok) begin
                    low_count <= in_count;
                    if (in_carry) begin
                        if (in_dir) begin
                            high_count <= high_count + HIGH_W'(1);
                            wrap       <= (high_count == HIGH_MAX);
                        end else begin
                            high_count <= high_count - HIGH_W'(1);
                            wrap       <= (high_count == '0);
                        end
                    end
                end else begin
                    err    <= 1'b1;
                    state  <= ERR;
                    locked <= 1'b0;
                end
            end
        end
    end

`ifdef COUNT_TRACKER_ERRCNT_EN
    logic bad_sample;

    // An illegal sample is one rejected while acquiring or tracking; samples ignored in ERR do not count
    always_comb begin
        bad_sample = 1'b0;
        if (in_valid) begin
            if (acquiring)
                bad_sample = !ref_ok;
            else if (state == TRACK)
                bad_sample = !step_ok;
        end
    end

    // Saturating error counter, survives resync and clears only on rst
    always_ff @(posedge clk) begin
        if (rst)
            err_count <= 8'd0;
        else if (bad_sample && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_count_tracker.sv
// tb/tb_count_tracker.sv - table-driven bench for count_tracker
module tb_count_tracker;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_count;
    logic       in_carry;
    logic       in_dir;
    logic       resync;
    logic [3:0] low_count;
    logic [7:0] high_count;
    logic       locked;
    logic       err;
    logic       wrap;
`ifdef COUNT_TRACKER_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int total = 0;
    int bad   = 0;

    count_tracker #(.MODULO(11), .HIGH_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_count   (in_count),
        .in_carry   (in_carry),
        .in_dir     (in_dir),
        .resync     (resync),
        .low_count  (low_count),
        .high_count (high_count),
        .locked     (locked),
        .err        (err),
`ifdef COUNT_TRACKER_ERRCNT_EN
        .err_count  (err_count),
`endif
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [3:0] count;
        logic       carry;
        logic       dir;
        logic       resync;
        logic [3:0] e_low;
        logic [7:0] e_high;
        logic       e_locked;
        logic       e_err;
        logic       e_wrap;
        logic [7:0] e_errcnt;
    } vec_t;

    vec_t vecs[$];

    task automatic push(input logic r, input logic v, input int c, input logic cy, input logic d,
                        input logic rs, input int lo, input int hi, input logic lk, input logic er,
                        input logic wr, input int ec);
        vec_t x;
        x.rst = r; x.valid = v; x.count = 4'(c); x.carry = cy; x.dir = d; x.resync = rs;
        x.e_low = 4'(lo); x.e_high = 8'(hi); x.e_locked = lk; x.e_err = er; x.e_wrap = wr;
        x.e_errcnt = 8'(ec);
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] c, input logic cy,
                         input logic d, input logic rs);
        rst = r; in_valid = v; in_count = c; in_carry = cy; in_dir = d; resync = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_count = 4'd0; in_carry = 1'b0; in_dir = 1'b0; resync = 1'b0;

        //    rst v  cnt cy d  rs  low high lk er wr ec
        push(1, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0);
        push(0, 1, 0, 0, 1, 0,  0,  0,  1, 0, 0, 0);
        for (int k = 1; k <= 10; k++)
            push(0, 1, k, 0, 1, 0,  k,  0,  1, 0, 0, 0);
        push(0, 1, 0, 1, 1, 0,  0,  1,  1, 0, 0, 0);
        push(0, 0, 5, 1, 0, 0,  0,  1,  1, 0, 0, 0);
        push(0, 1, 10, 1, 0, 0, 10, 0,  1, 0, 0, 0);
        push(0, 1, 9, 0, 0, 0,  9,  0,  1, 0, 0, 0);
        for (int k = 8; k >= 0; k--)
            push(0, 1, k, 0, 0, 0,  k,  0,  1, 0, 0, 0);
        push(0, 1, 10, 1, 0, 0, 10, 255, 1, 0, 1, 0);
        push(0, 0, 0, 0, 0, 0,  10, 255, 1, 0, 0, 0);
        push(0, 1, 0, 1, 1, 0,  0,  0,  1, 0, 1, 0);
        for (int k = 1; k <= 4; k++)
            push(0, 1, k, 0, 1, 0,  k,  0,  1, 0, 0, 0);
        push(0, 1, 6, 0, 1, 0,  4,  0,  0, 1, 0, 1);
        push(0, 1, 5, 0, 1, 0,  4,  0,  0, 1, 0, 1);
        push(0, 1, 7, 0, 1, 1,  7,  0,  1, 0, 0, 1);
        push(0, 1, 8, 0, 1, 0,  8,  0,  1, 0, 0, 1);
        push(0, 1, 9, 0, 1, 0,  9,  0,  1, 0, 0, 1);
        push(0, 1, 10, 0, 1, 0, 10, 0,  1, 0, 0, 1);
        push(0, 1, 0, 0, 1, 0,  10, 0,  0, 1, 0, 2);
        push(0, 0, 0, 0, 1, 1,  10, 0,  0, 0, 0, 2);
        push(0, 1, 12, 0, 1, 0, 10, 0,  0, 1, 0, 3);
        push(0, 1, 11, 0, 1, 1, 10, 0,  0, 1, 0, 4);
        push(0, 1, 3, 0, 1, 1,  3,  0,  1, 0, 0, 4);
        push(0, 1, 4, 1, 1, 0,  3,  0,  0, 1, 0, 5);
        push(0, 1, 0, 0, 1, 1,  0,  0,  1, 0, 0, 5);
        push(0, 1, 10, 0, 0, 0, 0,  0,  0, 1, 0, 6);
        push(1, 1, 5, 0, 1, 1,  0,  0,  0, 0, 0, 0);
        push(0, 1, 5, 0, 1, 0,  5,  0,  1, 0, 0, 0);
        push(0, 1, 6, 0, 1, 0,  6,  0,  1, 0, 0, 0);
        push(0, 1, 5, 0, 0, 0,  5,  0,  1, 0, 0, 0);
        push(0, 1, 4, 0, 0, 0,  4,  0,  1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].count, vecs[i].carry, vecs[i].dir, vecs[i].resync);
            check("low_count",  i, int'(low_count),  int'(vecs[i].e_low));
            check("high_count", i, int'(high_count), int'(vecs[i].e_high));
            check("locked",     i, int'(locked),     int'(vecs[i].e_locked));
            check("err",        i, int'(err),        int'(vecs[i].e_err));
            check("wrap",       i, int'(wrap),       int'(vecs[i].e_wrap));
`ifdef COUNT_TRACKER_ERRCNT_EN
            check("err_count",  i, int'(err_count),  int'(vecs[i].e_errcnt));
`endif
        end

        // ERR ignores a long run of samples, including ones that would be legal steps
        drive(0, 1, 2, 0, 1, 0);
        check("err_enter", 0, int'(err), 1);
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 4'(k % 11), 1'(k % 3 == 0), 1'(k % 2), 0);
            check("err_hold_low",  k, int'(low_count), 4);
            check("err_hold_lock", k, int'(locked), 0);
            check("err_hold_err",  k, int'(err), 1);
        end

`ifdef COUNT_TRACKER_ERRCNT_EN
        // Repeated resync with an out-of-range reference: each is a fresh illegal sample until saturation
        for (int k = 0; k < 260; k++)
            drive(0, 1, 4'd15, 0, 1, 1);
        check("err_count_sat", 0, int'(err_count), 255);
        drive(0, 1, 4'd1, 0, 1, 1);
        check("err_count_keep", 0, int'(err_count), 255);
        check("resync_lock", 0, int'(locked), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
